// File: rtl/conv1_window_gen.sv
// Streaming 3x3xCH sliding-window generator: buffers two image rows and emits
// a packed window for every valid (unpadded) output position in raster order.
module conv1_window_gen #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned CH     = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned STRIDE = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [CH*DW-1:0]       in_pixel,
  output logic                   out_valid,
  output logic [CH*9*DW-1:0]     out_window,
  output logic                   out_last
);

  localparam int unsigned PW     = CH * DW;
  localparam int unsigned WW     = CH * 9 * DW;
  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned LAST_C = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;
  localparam int unsigned LAST_R = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;

  logic [CW-1:0] col, cur_col, col_nxt;
  logic [RW-1:0] row, cur_row, row_nxt;
  logic          col_wrap;
  logic          stride_ok;
  logic          emit;
  logic          is_last;

  logic [PW-1:0] lb0 [IMG_W];
  logic [PW-1:0] lb1 [IMG_W];

  logic [2:0][2:0][PW-1:0] win_q, win_d;
  logic [WW-1:0]           win_pack;

  // Position of the incoming pixel; in_sof overrides the counters
  always_comb begin
    cur_col   = in_sof ? '0 : col;
    cur_row   = in_sof ? '0 : row;
    col_wrap  = (cur_col == CW'(IMG_W - 1));
    col_nxt   = col_wrap ? '0 : cur_col + CW'(1);
    row_nxt   = cur_row;
    if (col_wrap) begin
      row_nxt = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end
    stride_ok = (STRIDE == 1) || (!cur_col[0] && !cur_row[0]);
    emit      = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2)) && stride_ok;
    is_last   = (cur_row == RW'(LAST_R)) && (cur_col == CW'(LAST_C));
  end

  // Window shifts left; new column {row-2, row-1, current} enters at kc=2
  always_comb begin
    win_d = win_q;
    for (int kr = 0; kr < 3; kr++) begin
      win_d[kr][0] = win_q[kr][1];
      win_d[kr][1] = win_q[kr][2];
    end
    win_d[0][2] = lb1[cur_col];
    win_d[1][2] = lb0[cur_col];
    win_d[2][2] = in_pixel;
  end

  // Repack as channel-major, tap-minor for the conv stage
  always_comb begin
    win_pack = '0;
    for (int k = 0; k < CH; k++) begin
      for (int kr = 0; kr < 3; kr++) begin
        for (int kc = 0; kc < 3; kc++) begin
          win_pack[(k*9 + kr*3 + kc)*DW +: DW] = win_d[2'(kr)][2'(kc)][k*DW +: DW];
        end
      end
    end
  end

  // Line buffers: contents never reset, stale rows are gated by the row counter
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col        <= '0;
      row        <= '0;
      win_q      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= emit && is_last;
      if (emit) begin
        out_window <= win_pack;
      end
      if (in_valid) begin
        col   <= col_nxt;
        row   <= row_nxt;
        win_q <= win_d;
      end
    end
  end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Bench for conv1_window_gen on a 5x5x3 image, stride 1 and stride 2 instances
// side by side, checked against an image-array reference of every window.
module tb_conv1_window_gen;

  localparam int unsigned IW = 5;
  localparam int unsigned IH = 5;
  localparam int unsigned CH = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = CH * DW;
  localparam int unsigned WW = CH * 9 * DW;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid, in_sof;
  logic [PW-1:0] in_pixel;
  logic v1, l1, v2, l2;
  logic [WW-1:0] w1, w2;

  always #5 clk = ~clk;

  conv1_window_gen #(.IMG_W(IW), .IMG_H(IH), .CH(CH), .DW(DW), .STRIDE(1)) dut_s1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(v1), .out_window(w1), .out_last(l1)
  );

  conv1_window_gen #(.IMG_W(IW), .IMG_H(IH), .CH(CH), .DW(DW), .STRIDE(2)) dut_s2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(v2), .out_window(w2), .out_last(l2)
  );

  typedef struct {
    int dut;
    int idx;
    int tr;
    int tc;
    bit last;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] img [IH][IW];
  logic [WW-1:0] hold1, hold2;
  logic [WW-1:0] cap1[$], cap2[$], ref_cap1[$];
  bit capl1[$], capl2[$];
  int nwin1, nwin2, nlast1, nlast2;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix_of(input int r, input int c);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'(32*k + 5*r + c);
    return p;
  endfunction

  // Reference window from the image as driven in the current frame
  function automatic logic [WW-1:0] ref_win(input int r, input int c);
    logic [WW-1:0] res;
    res = '0;
    for (int k = 0; k < CH; k++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          res[(k*9 + kr*3 + kc)*DW +: DW] = img[r-2+kr][c-2+kc][k*DW +: DW];
    return res;
  endfunction

  function automatic bit emits(input int r, input int c, input int s);
    return (r >= 2) && (c >= 2) && ((r-2) % s == 0) && ((c-2) % s == 0);
  endfunction

  function automatic bit last_pos(input int r, input int c, input int s);
    return (r == 2 + ((IH-3)/s)*s) && (c == 2 + ((IW-3)/s)*s);
  endfunction

  task automatic check_outs(input int r, input int c, input bit px);
    bit e1, e2;
    e1 = px && emits(r, c, 1);
    e2 = px && emits(r, c, 2);
    chk("valid_s1", WW'(v1), WW'(e1));
    chk("valid_s2", WW'(v2), WW'(e2));
    if (e1) begin
      hold1 = ref_win(r, c);
      chk("last_s1", WW'(l1), WW'(last_pos(r, c, 1)));
    end
    if (e2) begin
      hold2 = ref_win(r, c);
      chk("last_s2", WW'(l2), WW'(last_pos(r, c, 2)));
    end
    chk("window_s1", w1, hold1);
    chk("window_s2", w2, hold2);
    if (v1) begin nwin1++; cap1.push_back(w1); capl1.push_back(l1); if (l1) nlast1++; end
    if (v2) begin nwin2++; cap2.push_back(w2); capl2.push_back(l2); if (l2) nlast2++; end
  endtask

  task automatic send(input int r, input int c, input bit sof, input logic [PW-1:0] pix);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    img[r][c] = pix;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'($urandom);
    in_pixel = PW'($urandom);
    check_outs(r, c, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outs(0, 0, 1'b0);
    end
  endtask

  task automatic frame(input bit sof, input bit rnd, input bit gaps, input int npix);
    int n;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        n = 0;
        while ((($urandom % 2) == 1) && (n < 6)) n++;
        idle(n);
      end
      send(i / IW, i % IW, sof && (i == 0), rnd ? PW'($urandom) : pix_of(i / IW, i % IW));
    end
  endtask

  task automatic clr();
    nwin1 = 0; nwin2 = 0; nlast1 = 0; nlast2 = 0;
    cap1.delete(); cap2.delete(); capl1.delete(); capl2.delete();
  endtask

  task automatic counts(input string tag, input int e1, input int el1, input int e2, input int el2);
    chk({tag, "_nwin_s1"}, WW'(nwin1), WW'(e1));
    chk({tag, "_nlast_s1"}, WW'(nlast1), WW'(el1));
    chk({tag, "_nwin_s2"}, WW'(nwin2), WW'(e2));
    chk({tag, "_nlast_s2"}, WW'(nlast2), WW'(el2));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_valid_s1"}, WW'(v1), '0);
    chk({tag, "_last_s1"}, WW'(l1), '0);
    chk({tag, "_window_s1"}, w1, '0);
    chk({tag, "_valid_s2"}, WW'(v2), '0);
    chk({tag, "_last_s2"}, WW'(l2), '0);
    chk({tag, "_window_s2"}, w2, '0);
  endtask

  initial begin
    vec_t tbl[7];
    logic [WW-1:0] exp_w, act_w;
    bit act_l, have;

    tbl[0] = '{1, 0, 0, 0, 1'b0};
    tbl[1] = '{1, 1, 0, 1, 1'b0};
    tbl[2] = '{1, 8, 2, 2, 1'b1};
    tbl[3] = '{2, 0, 0, 0, 1'b0};
    tbl[4] = '{2, 1, 0, 2, 1'b0};
    tbl[5] = '{2, 2, 2, 0, 1'b0};
    tbl[6] = '{2, 3, 2, 2, 1'b1};

    rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
    hold1 = '0; hold2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Stride 1 and 2 on the counting image
    clr();
    frame(1'b1, 1'b0, 1'b0, IW*IH);
    idle(2);
    counts("plain", 9, 1, 4, 1);
    ref_cap1 = cap1;
    for (int t = 0; t < 7; t++) begin
      exp_w = '0;
      for (int k = 0; k < CH; k++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            exp_w[(k*9 + kr*3 + kc)*DW +: DW] = DW'(32*k + 5*(tbl[t].tr + kr) + tbl[t].tc + kc);
      have = (tbl[t].dut == 1) ? (tbl[t].idx < cap1.size()) : (tbl[t].idx < cap2.size());
      if (!have) begin
        checks++; failures++;
        $display("FAIL table_%0d: window %0d missing on stride %0d", t, tbl[t].idx, tbl[t].dut);
      end else begin
        act_w = (tbl[t].dut == 1) ? cap1[tbl[t].idx] : cap2[tbl[t].idx];
        act_l = (tbl[t].dut == 1) ? capl1[tbl[t].idx] : capl2[tbl[t].idx];
        chk($sformatf("table_%0d_window", t), act_w, exp_w);
        chk($sformatf("table_%0d_last", t), WW'(act_l), WW'(tbl[t].last));
      end
    end

    // Random input gaps must not change the window sequence
    clr();
    frame(1'b1, 1'b0, 1'b1, IW*IH);
    idle(2);
    counts("gaps", 9, 1, 4, 1);
    for (int i = 0; i < 9; i++) begin
      if (i < cap1.size() && i < ref_cap1.size()) chk($sformatf("gaps_seq_%0d", i), cap1[i], ref_cap1[i]);
    end

    // Resync: sof on pixel 13 of a partial frame, then a full random frame
    clr();
    frame(1'b1, 1'b0, 1'b0, 13);
    counts("partial", 1, 0, 1, 0);
    clr();
    frame(1'b1, 1'b1, 1'b0, IW*IH);
    idle(1);
    counts("resync", 9, 1, 4, 1);

    // Asynchronous reset mid-frame, then a frame without sof
    clr();
    frame(1'b1, 1'b1, 1'b0, 18);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst_hold");
    hold1 = '0; hold2 = '0;
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    clr();
    frame(1'b0, 1'b1, 1'b0, IW*IH);
    idle(2);
    counts("post_rst", 9, 1, 4, 1);

    // Back-to-back frames, second relies on the row wrap
    clr();
    frame(1'b1, 1'b1, 1'b0, IW*IH);
    frame(1'b0, 1'b1, 1'b1, IW*IH);
    idle(2);
    counts("b2b", 18, 2, 8, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
